pipelined_addsub_unit: RTL and testbench

Parametrised, pipelined successor to the combinational carry-lookahead adder in the ALU datapath. It performs add, subtract, add-with-carry and subtract-with-borrow on N-bit two's-complement operands, with optional signed saturation. The carry chain is split into SEG-bit segments, one per pipeline stage, so the block closes timing at wide N. A valid/ready handshake on both sides lets the UART command decoder feed it and the response serialiser drain it with backpressure. Flags extend the existing {V,N,Z,P} set with a carry flag.

---
 rtl/pipelined_addsub_unit.sv | 148 ++++++++++++++
 tb/tb_pipelined_addsub_unit.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_addsub_unit.sv
// Pipelined add/subtract unit: the carry chain is cut into SEG-bit segments, one per stage,
// followed by a result stage that applies optional signed saturation and produces {C,V,N,Z,P}.
module pipelined_addsub_unit #(
  parameter int N   = 16,
  parameter int SEG = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [1:0]   op,
  input  logic         cin,
  input  logic         sat,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] result,
  output logic [4:0]   flags
);

  localparam int NS = N / SEG;

  logic         advance;
  logic         accept;
  logic [N-1:0] b_eff;
  logic         c0;

  // Stage registers; operand words ride along whole so the last stage still sees both sign bits.
  logic         st_vld [NS];
  logic         st_c   [NS];
  logic         st_sat [NS];
  logic [N-1:0] st_a   [NS];
  logic [N-1:0] st_b   [NS];
  logic [N-1:0] st_sum [NS];

  logic         pin_vld [NS];
  logic         pin_c   [NS];
  logic         pin_sat [NS];
  logic [N-1:0] pin_a   [NS];
  logic [N-1:0] pin_b   [NS];
  logic [N-1:0] pin_sum [NS];

  logic [N-1:0] nxt_sum [NS];
  logic         nxt_c   [NS];

  logic [N-1:0] raw;
  logic         ovf;
  logic         a_msb;
  logic         b_msb;
  logic [N-1:0] fin;

  assign advance  = out_ready | ~out_valid;
  assign in_ready = advance;
  assign accept   = in_valid & in_ready;

  // SUB and SBB (op[0]=1) invert B; the carry-in carries the operation's +1 or the external cin.
  always_comb begin
    b_eff = op[0] ? ~b : b;
    case (op)
      2'b00:   c0 = 1'b0;
      2'b01:   c0 = 1'b1;
      default: c0 = cin;
    endcase
  end

  always_comb begin
    pin_vld[0] = accept;
    pin_a[0]   = a;
    pin_b[0]   = b_eff;
    pin_c[0]   = c0;
    pin_sat[0] = sat;
    pin_sum[0] = '0;
    for (int k = 1; k < NS; k++) begin
      pin_vld[k] = st_vld[k-1];
      pin_a[k]   = st_a[k-1];
      pin_b[k]   = st_b[k-1];
      pin_c[k]   = st_c[k-1];
      pin_sat[k] = st_sat[k-1];
      pin_sum[k] = st_sum[k-1];
    end
  end

  // Each stage resolves its own segment from generate/propagate and the incoming segment carry.
  always_comb begin
    for (int k = 0; k < NS; k++) begin
      logic carry;
      logic g;
      logic p;
      carry      = pin_c[k];
      nxt_sum[k] = pin_sum[k];
      for (int i = 0; i < SEG; i++) begin
        g = pin_a[k][k*SEG+i] & pin_b[k][k*SEG+i];
        p = pin_a[k][k*SEG+i] ^ pin_b[k][k*SEG+i];
        nxt_sum[k][k*SEG+i] = p ^ carry;
        carry = g | (p & carry);
      end
      nxt_c[k] = carry;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NS; k++) begin
        st_vld[k] <= 1'b0;
        st_c[k]   <= 1'b0;
        st_sat[k] <= 1'b0;
        st_a[k]   <= '0;
        st_b[k]   <= '0;
        st_sum[k] <= '0;
      end
    end else if (advance) begin
      for (int k = 0; k < NS; k++) begin
        st_vld[k] <= pin_vld[k];
        st_c[k]   <= nxt_c[k];
        st_sat[k] <= pin_sat[k];
        st_a[k]   <= pin_a[k];
        st_b[k]   <= pin_b[k];
        st_sum[k] <= nxt_sum[k];
      end
    end
  end

  // Overflow is judged on the unsaturated sum; saturation direction follows the sign of A.
  always_comb begin
    raw   = st_sum[NS-1];
    a_msb = st_a[NS-1][N-1];
    b_msb = st_b[NS-1][N-1];
    ovf   = (a_msb == b_msb) & (raw[N-1] != a_msb);
    fin   = raw;
    if (st_sat[NS-1] && ovf) begin
      fin = a_msb ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      result    <= '0;
      flags     <= '0;
    end else if (advance) begin
      out_valid <= st_vld[NS-1];
      result    <= fin;
      flags     <= {st_c[NS-1], ovf, fin[N-1], (fin == '0), ~^fin};
    end
  end

endmodule

// File: tb/tb_pipelined_addsub_unit.sv
// Bench for pipelined_addsub_unit: directed vector table, stall/stream sequences,
// randomized traffic against an arithmetic reference model, and a mid-flight reset.
module tb_pipelined_addsub_unit;

  localparam int N   = 16;
  localparam int SEG = 4;
  localparam int LAT = N / SEG + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [N-1:0]  a = '0;
  logic [N-1:0]  b = '0;
  logic [1:0]    op = 2'b00;
  logic          cin = 1'b0;
  logic          sat = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [N-1:0]  result;
  logic [4:0]    flags;

  int compared   = 0;
  int mismatched = 0;
  int accepted   = 0;

  typedef struct {
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [1:0]   op;
    logic         cin;
    logic         sat;
    logic [N-1:0] res;
    logic [4:0]   flg;
  } vec_t;

  typedef struct {
    logic [N-1:0] res;
    logic [4:0]   flg;
  } exp_t;

  vec_t vecs [6];
  exp_t sbq [$];

  logic        hold_pending = 1'b0;
  logic [31:0] held_word = '0;

  always #5 clk = ~clk;

  pipelined_addsub_unit #(.N(N), .SEG(SEG)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .cin       (cin),
    .sat       (sat),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .flags     (flags)
  );

  // Reference: true signed value decides overflow, unsigned comparison decides carry/no-borrow.
  function automatic exp_t refModel(input logic [N-1:0] ra, input logic [N-1:0] rb,
                                    input logic [1:0] rop, input logic rcin, input logic rsat);
    exp_t e;
    int sa, sb, ua, ub, ideal;
    logic c, v;
    sa = int'($signed(ra));
    sb = int'($signed(rb));
    ua = int'({16'b0, ra});
    ub = int'({16'b0, rb});
    case (rop)
      2'b00: begin ideal = sa + sb;                  c = (ua + ub) > 65535;               end
      2'b01: begin ideal = sa - sb;                  c = (ua >= ub);                      end
      2'b10: begin ideal = sa + sb + int'(rcin);     c = (ua + ub + int'(rcin)) > 65535;  end
      default: begin ideal = sa - sb - int'(!rcin);  c = (ua >= ub + int'(!rcin));        end
    endcase
    v = (ideal > 32767) || (ideal < -32768);
    if (rsat && v) e.res = (ideal > 0) ? 16'h7FFF : 16'h8000;
    else           e.res = 16'(ideal);
    e.flg = {c, v, e.res[N-1], (e.res == 16'h0000), ~^e.res};
    return e;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // One clock of traffic: drive on the falling edge, then score whatever handshakes will fire.
  task automatic applyStimulus(input logic iv, input logic ordy);
    exp_t e;
    @(negedge clk);
    if (hold_pending) begin
      checkOutput("held out_valid", {31'b0, out_valid}, 32'd1);
      checkOutput("held result/flags", {11'b0, result, flags}, held_word);
    end
    out_ready = ordy;
    in_valid  = iv;
    a   = 16'($urandom);
    b   = 16'($urandom);
    op  = 2'($urandom);
    cin = 1'($urandom);
    sat = 1'($urandom);
    #1;
    if (out_valid && out_ready) begin
      if (sbq.size() == 0) begin
        compared++;
        mismatched++;
        $display("[TB] FAIL unexpected beat: got 0x%0h with empty scoreboard", {result, flags});
      end else begin
        e = sbq.pop_front();
        checkOutput("stream beat", {11'b0, result, flags}, {11'b0, e.res, e.flg});
      end
    end
    if (in_valid && in_ready) begin
      sbq.push_back(refModel(a, b, op, cin, sat));
      accepted++;
    end
    hold_pending = out_valid && !out_ready;
    held_word    = {11'b0, result, flags};
  endtask

  task automatic drain();
    int n = 0;
    while (sbq.size() > 0 && n < 200) begin
      applyStimulus(1'b0, 1'b1);
      n++;
    end
    checkOutput("drain leftover beats", 32'(sbq.size()), 32'd0);
    hold_pending = 1'b0;
  endtask

  task automatic runDirected(input vec_t v, input int idx);
    int lat;
    @(negedge clk);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    a = v.a; b = v.b; op = v.op; cin = v.cin; sat = v.sat;
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    in_valid = 1'b0;
    a = 16'($urandom); b = 16'($urandom); op = 2'($urandom); sat = ~v.sat; cin = ~v.cin;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    checkOutput($sformatf("vec%0d latency", idx), 32'(lat), 32'(LAT));
    checkOutput($sformatf("vec%0d result", idx), {16'b0, result}, {16'b0, v.res});
    checkOutput($sformatf("vec%0d flags", idx), {27'b0, flags}, {27'b0, v.flg});
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int cyc;
    //                 a         b         op     cin   sat   result    {C,V,N,Z,P}
    vecs[0] = '{16'h7FFF, 16'h0001, 2'b00, 1'b0, 1'b0, 16'h8000, 5'b01100};
    vecs[1] = '{16'h7FFF, 16'h0001, 2'b00, 1'b0, 1'b1, 16'h7FFF, 5'b01000};
    vecs[2] = '{16'h0005, 16'h0005, 2'b01, 1'b0, 1'b0, 16'h0000, 5'b10011};
    vecs[3] = '{16'h8000, 16'h0001, 2'b01, 1'b0, 1'b1, 16'h8000, 5'b11100};
    vecs[4] = '{16'hFFFF, 16'h0000, 2'b10, 1'b1, 1'b0, 16'h0000, 5'b10011};
    vecs[5] = '{16'h0003, 16'h0001, 2'b11, 1'b0, 1'b0, 16'h0001, 5'b10000};

    #12;
    checkOutput("reset out_valid", {31'b0, out_valid}, 32'd0);
    checkOutput("reset result", {16'b0, result}, 32'd0);
    checkOutput("reset flags", {27'b0, flags}, 32'd0);
    checkOutput("reset in_ready", {31'b0, in_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 6; i++) runDirected(vecs[i], i);
    repeat (3) @(negedge clk);

    // Eight back-to-back beats with a three-cycle downstream stall once results start flowing.
    accepted = 0;
    cyc = 0;
    while (accepted < 8 && cyc < 60) begin
      applyStimulus(1'b1, !(cyc >= 5 && cyc <= 7));
      checkOutput($sformatf("stream in_ready c%0d", cyc), {31'b0, in_ready},
                  (cyc >= 5 && cyc <= 7) ? 32'd0 : 32'd1);
      cyc++;
    end
    checkOutput("stream accepted", 32'(accepted), 32'd8);
    drain();

    accepted = 0;
    cyc = 0;
    while (accepted < 1000 && cyc < 20000) begin
      applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0);
      cyc++;
    end
    checkOutput("random accepted", 32'(accepted), 32'd1000);
    drain();

    // Fill the pipe, park a result at the output, then reset in the middle of a low phase.
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b1);
    applyStimulus(1'b1, 1'b0);
    checkOutput("pre-reset out_valid", {31'b0, out_valid}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async reset out_valid", {31'b0, out_valid}, 32'd0);
    checkOutput("async reset result", {16'b0, result}, 32'd0);
    checkOutput("async reset flags", {27'b0, flags}, 32'd0);
    sbq.delete();
    hold_pending = 1'b0;
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    runDirected(vecs[3], 6);
    repeat (2) @(negedge clk);
    checkOutput("post-reset no stale beat", {31'b0, out_valid}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
